// File: rtl/rv_alu_exec.sv
// rv_alu_exec: execute-stage ALU with registered, back-pressurable result.
// Define ALU_SERIAL_SHIFT_EN to run shifts one bit per cycle.
module rv_alu_exec #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      alu_op_sel_i,
  input  logic            alu_op_32b_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  logic            is_w;
  logic            legal;
  logic            is_shift;
  logic            fire;
  logic            idle;
  logic [5:0]      shamt;
  logic [31:0]     a32;
  logic [31:0]     b32;
  logic [31:0]     w32;
  logic [XLEN-1:0] full;
  logic [XLEN-1:0] res_d;

  logic            valid_q;
  logic            zero_q;
  logic            illegal_q;
  logic [XLEN-1:0] result_q;

  always_comb begin
    is_w     = (XLEN == 64) && alu_op_32b_i;
    shamt    = (is_w || (XLEN == 32)) ? {1'b0, op_b_i[4:0]}
                                      : op_b_i[5:0];
    a32      = op_a_i[31:0];
    b32      = op_b_i[31:0];
    full     = '0;
    w32      = '0;
    legal    = 1'b1;
    is_shift = 1'b0;
    case (alu_op_sel_i)
      OP_ADD: begin
        full = op_a_i + op_b_i;
        w32  = a32 + b32;
      end
      OP_SUB: begin
        full = op_a_i - op_b_i;
        w32  = a32 - b32;
      end
`ifdef ALU_SERIAL_SHIFT_EN
      // Shift amount 0 completes here; k>0 goes to the serial shifter.
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift = 1'b1;
        full     = op_a_i;
        w32      = a32;
      end
`else
      OP_SLL: begin
        is_shift = 1'b1;
        full     = op_a_i << shamt;
        w32      = a32 << shamt[4:0];
      end
      OP_SRL: begin
        is_shift = 1'b1;
        full     = op_a_i >> shamt;
        w32      = a32 >> shamt[4:0];
      end
      OP_SRA: begin
        is_shift = 1'b1;
        full     = $signed(op_a_i) >>> shamt;
        w32      = $signed(a32) >>> shamt[4:0];
      end
`endif
      OP_SLT: begin
        full  = XLEN'($signed(op_a_i) < $signed(op_b_i));
        legal = !is_w;
      end
      OP_SLTU: begin
        full  = XLEN'(op_a_i < op_b_i);
        legal = !is_w;
      end
      OP_XOR: begin
        full  = op_a_i ^ op_b_i;
        legal = !is_w;
      end
      OP_OR: begin
        full  = op_a_i | op_b_i;
        legal = !is_w;
      end
      OP_AND: begin
        full  = op_a_i & op_b_i;
        legal = !is_w;
      end
      default: legal = 1'b0;
    endcase
    res_d = is_w ? XLEN'($signed(w32)) : full;
    if (!legal) res_d = '0;
  end

`ifdef ALU_SERIAL_SHIFT_EN
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] work_q;
  logic [3:0]      op_q;
  logic            w_q;
  logic [XLEN-1:0] step_d;
  logic [XLEN-1:0] fin_d;

  // Word right shifts refill bit 31; upper bits are discarded at the end.
  always_comb begin
    step_d = {1'b0, work_q[XLEN-1:1]};
    if (op_q == OP_SLL) begin
      step_d = work_q << 1;
    end else begin
      if (op_q == OP_SRA) step_d[XLEN-1] = work_q[XLEN-1];
      if (w_q) step_d[31] = (op_q == OP_SRA) && work_q[31];
    end
    fin_d = w_q ? XLEN'($signed(step_d[31:0])) : step_d;
  end

  assign idle = (state_q == IDLE);
`else
  assign idle = 1'b1;
`endif

  assign ready_o = idle && (!valid_q || ready_i);
  assign fire    = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      op_q      <= '0;
      w_q       <= 1'b0;
`endif
    end else if (flush_i) begin
      valid_q   <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      state_q   <= IDLE;
      cnt_q     <= '0;
`endif
    end else begin
      if (valid_q && ready_i) valid_q <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
      if (state_q == SHIFT) begin
        work_q <= step_d;
        cnt_q  <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_q   <= IDLE;
          valid_q   <= 1'b1;
          result_q  <= fin_d;
          zero_q    <= (fin_d == '0);
          illegal_q <= 1'b0;
        end
      end else if (fire && is_shift && (shamt != 6'd0)) begin
        state_q <= SHIFT;
        cnt_q   <= shamt;
        work_q  <= op_a_i;
        op_q    <= alu_op_sel_i;
        w_q     <= is_w;
      end else
`endif
      if (fire) begin
        valid_q   <= 1'b1;
        result_q  <= res_d;
        zero_q    <= (res_d == '0);
        illegal_q <= !legal;
      end
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_rv_alu_exec.sv
// tb_rv_alu_exec: randomized and directed checks of rv_alu_exec
// against a behavioural ALU reference model (XLEN=64).
module tb_rv_alu_exec;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  alu_op_sel_i;
  logic        alu_op_32b_i;
  logic [63:0] op_a_i;
  logic [63:0] op_b_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] result_o;
  logic        zero_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  rv_alu_exec #(.XLEN(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .alu_op_sel_i (alu_op_sel_i),
    .alu_op_32b_i (alu_op_32b_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .zero_o       (zero_o),
    .illegal_o    (illegal_o)
  );

  function automatic void model(input logic [3:0] op, input bit w,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output bit ill);
    int unsigned sh;
    logic [31:0] ua, ub, r32;
    sh  = w ? 32'(b[4:0]) : 32'(b[5:0]);
    ua  = a[31:0];
    ub  = b[31:0];
    r   = '0;
    r32 = '0;
    ill = 1'b0;
    if (!w) begin
      case (op)
        4'h0: r = a + b;
        4'h8: r = a - b;
        4'h1: r = a << sh;
        4'h2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        4'h3: r = (a < b) ? 64'd1 : 64'd0;
        4'h4: r = a ^ b;
        4'h5: r = a >> sh;
        4'hD: r = $signed(a) >>> sh;
        4'h6: r = a | b;
        4'h7: r = a & b;
        default: ill = 1'b1;
      endcase
    end else begin
      case (op)
        4'h0: r32 = ua + ub;
        4'h8: r32 = ua - ub;
        4'h1: r32 = ua << sh;
        4'h5: r32 = ua >> sh;
        4'hD: r32 = $signed(ua) >>> sh;
        default: ill = 1'b1;
      endcase
      if (!ill) r = {{32{r32[31]}}, r32};
    end
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input bit w,
                                 input logic [63:0] b);
    int sh;
    sh = w ? int'(b[4:0]) : int'(b[5:0]);
`ifdef ALU_SERIAL_SHIFT_EN
    if ((op == 4'h1 || op == 4'h5 || op == 4'hD) && sh > 0) return sh;
`else
    if (op == 4'hF && sh < 0) return 0;
`endif
    return 1;
  endfunction

  task automatic send_op(input logic [3:0] op, input bit w,
                         input logic [63:0] a, input logic [63:0] b);
    alu_op_sel_i = op;
    alu_op_32b_i = w;
    op_a_i       = a;
    op_b_i       = b;
    valid_i      = 1'b1;
    @(posedge clk); #1;
    valid_i      = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    checks++;
    if (result_o !== 64'd0) begin
      errors++; $display("FAIL reset_result: got %h want 0", result_o);
    end
    checks++;
    if (zero_o !== 1'b0 || illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got z=%b i=%b want 0 0", zero_o, illegal_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", ready_o);
    end
    last_res = 64'd0;
  endtask

  task automatic test_directed();
    logic [3:0]  t_op [6] = '{4'h8, 4'hD, 4'h2, 4'h3, 4'hF, 4'h4};
    bit          t_w  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] t_a  [6] = '{64'd5, 64'h8000_0000, '1, '1,
                              64'h1234, 64'h55};
    logic [63:0] t_b  [6] = '{64'd7, 64'd4, 64'd1, 64'd1, 64'd9, 64'h0F};
    logic [63:0] t_r  [6] = '{64'hFFFF_FFFF_FFFF_FFFE,
                              64'hFFFF_FFFF_F800_0000,
                              64'd1, 64'd0, 64'd0, 64'd0};
    bit          t_il [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ready_i = 1'b1;
    for (int t = 0; t < 6; t++) begin
      int k;
      k = exp_lat(t_op[t], t_w[t], t_b[t]);
      send_op(t_op[t], t_w[t], t_a[t], t_b[t]);
      for (int i = 1; i < k; i++) begin
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
          errors++;
          $display("FAIL dir%0d_busy: got rdy=%b vld=%b want 0 0",
                   t, ready_o, valid_o);
        end
        @(posedge clk); #1;
      end
      checks++;
      if (valid_o !== 1'b1 || result_o !== t_r[t]) begin
        errors++;
        $display("FAIL dir%0d_result: got v=%b %h want v=1 %h",
                 t, valid_o, result_o, t_r[t]);
      end
      checks++;
      if (zero_o !== (t_r[t] == 0) || illegal_o !== t_il[t]) begin
        errors++;
        $display("FAIL dir%0d_flags: got z=%b i=%b want z=%b i=%b",
                 t, zero_o, illegal_o, t_r[t] == 0, t_il[t]);
      end
      last_res = t_r[t];
    end
  endtask

  task automatic test_random();
    logic [3:0] codes [10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3,
                               4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
    ready_i = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  op;
      bit          w, ill;
      logic [63:0] a, b, r;
      int          idx, lat;
      idx = int'($urandom_range(0, 10));
      op  = (idx == 10) ? 4'($urandom) : codes[idx];
      w   = ($urandom_range(0, 2) == 0);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = b;
      model(op, w, a, b, r, ill);
      send_op(op, w, a, b);
      wait_result(lat);
      checks++;
      if (lat != exp_lat(op, w, b)) begin
        errors++;
        $display("FAIL rnd%0d_latency: got %0d want %0d",
                 n, lat, exp_lat(op, w, b));
      end
      checks++;
      if (result_o !== r || illegal_o !== ill || zero_o !== (r == 0)) begin
        errors++;
        $display("FAIL rnd%0d op=%h w=%0d: got %h i=%b z=%b want %h i=%b",
                 n, op, w, result_o, illegal_o, zero_o, r, ill);
      end
      last_res = r;
    end
  endtask

  task automatic test_back_pressure();
    logic [63:0] a, b, r, r2;
    bit          ill;
    int          lat;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    model(4'h0, 1'b0, a, b, r, ill);
    send_op(4'h0, 1'b0, a, b);
    wait_result(lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || result_o !== r || ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b %h rdy=%b want v=1 %h rdy=0",
                 i, valid_o, result_o, ready_o, r);
      end
    end
    ready_i      = 1'b1;
    alu_op_sel_i = 4'h4;
    alu_op_32b_i = 1'b0;
    op_a_i       = a;
    op_b_i       = ~b;
    valid_i      = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", ready_o);
    end
    model(4'h4, 1'b0, a, ~b, r2, ill);
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || result_o !== r2) begin
      errors++;
      $display("FAIL bp_same_cycle: got v=%b %h want v=1 %h",
               valid_o, result_o, r2);
    end
    last_res = r2;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  codes [8] = '{4'h0, 4'h8, 4'h2, 4'h3,
                               4'h4, 4'h6, 4'h7, 4'hF};
    logic [63:0] exp_r [$];
    bit          ill;
    logic [63:0] r;
    ready_i = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b1 || result_o !== exp_r[n-1] ||
            ready_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b%0d: got v=%b %h rdy=%b want v=1 %h rdy=1",
                   n - 1, valid_o, result_o, ready_o, exp_r[n-1]);
        end
        last_res = exp_r[n-1];
      end
      if (n < 20) begin
        alu_op_sel_i = codes[$urandom_range(0, 7)];
        alu_op_32b_i = ($urandom_range(0, 3) == 0);
        op_a_i       = {$urandom, $urandom};
        op_b_i       = {$urandom, $urandom};
        model(alu_op_sel_i, alu_op_32b_i, op_a_i, op_b_i, r, ill);
        exp_r.push_back(r);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
    end
  endtask

  task automatic test_flush();
    logic [63:0] r;
    bit          ill;
    int          lat;
    ready_i = 1'b1;
    @(posedge clk); #1;
    alu_op_sel_i = 4'h0;
    alu_op_32b_i = 1'b0;
    op_a_i       = 64'd1;
    op_b_i       = 64'd1;
    valid_i      = 1'b1;
    flush_i      = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || result_o !== last_res || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_drop: got v=%b %h rdy=%b want v=0 %h rdy=1",
               valid_o, result_o, ready_o, last_res);
    end
    ready_i = 1'b0;
    model(4'h0, 1'b0, 64'd3, 64'd4, r, ill);
    send_op(4'h0, 1'b0, 64'd3, 64'd4);
    wait_result(lat);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || result_o !== r || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_held: got v=%b %h rdy=%b want v=0 %h rdy=1",
               valid_o, result_o, ready_o, r);
    end
    ready_i = 1'b1;
  endtask

  task automatic test_abort_shift();
`ifdef ALU_SERIAL_SHIFT_EN
    for (int pass = 0; pass < 2; pass++) begin
      bit rose;
      send_op(4'h1, 1'b0, 64'd1, 64'd20);
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
          errors++;
          $display("FAIL abort%0d_busy: got v=%b rdy=%b want 0 0",
                   pass, valid_o, ready_o);
        end
        @(posedge clk); #1;
      end
      if (pass == 0) flush_i = 1'b1;
      else           rst_i   = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      rst_i   = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL abort%0d_idle: got rdy=%b v=%b want 1 0",
                 pass, ready_o, valid_o);
      end
      rose = 1'b0;
      repeat (25) begin
        @(posedge clk); #1;
        if (valid_o) rose = 1'b1;
      end
      checks++;
      if (rose) begin
        errors++; $display("FAIL abort%0d_no_result: got 1 want 0", pass);
      end
    end
`else
    bit rose;
    send_op(4'h1, 1'b0, 64'd1, 64'd20);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    rose    = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid_o) rose = 1'b1;
    end
    checks++;
    if (rose || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_flush: got v=%b rdy=%b want 0 1", rose, ready_o);
    end
`endif
  endtask

  initial begin
    rst_i        = 1'b1;
    valid_i      = 1'b0;
    alu_op_sel_i = 4'h0;
    alu_op_32b_i = 1'b0;
    op_a_i       = '0;
    op_b_i       = '0;
    flush_i      = 1'b0;
    ready_i      = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_abort_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rv_alu_exec.md
# rv_alu_exec

- Execute-stage ALU for the dv-cpu-rv core.
- Consumes the 4-bit operation select and 32-bit-word flag from ALU control, plus the two operands from the operand muxes.
- Returns a registered result, a zero flag for branch resolution, and an illegal-op flag, using a valid/ready handshake on both sides.
- A single-entry output register holds the result under back-pressure; shifts may be executed serially to save area.

## Interface
- XLEN, 64: datapath width; 32 or 64.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  upstream operation valid.
- ready_o  out  1  block can accept an operation this cycle.
- alu_op_sel_i  in  4  {funct7[5], funct3} encoding: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and. All other codes, including 1111, are illegal.
- alu_op_32b_i  in  1  word operation (RV64 *W); tie to 0 when XLEN=32.
- op_a_i  in  XLEN  operand A.
- op_b_i  in  XLEN  operand B / shift amount.
- flush_i  in  1  pipeline flush; kills any in-flight or held operation.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  XLEN  result; stable while valid_o=1 and ready_i=0.
- zero_o  out  1  result_o==0.
- illegal_o  out  1  the accepted op code was illegal.

## Operation
- Accept rule: fire = valid_i & ready_o.
- ready_o = (state==IDLE) & (~valid_o | ready_i). Combinational, with no dependency on valid_i.
- States:
  - IDLE: waiting for an operation.
  - SHIFT: serial shifting in progress; only exists when serial shift is compiled in.
- add/sub: modulo 2^XLEN.
- slt/sltu: signed / unsigned compare; result is 1 or 0, zero-extended.
- Shift amount:
  - op_b_i[5:0] when XLEN=64 and alu_op_32b_i=0.
  - op_b_i[4:0] otherwise.
- Word ops (alu_op_32b_i=1, XLEN=64):
  - Compute on bits [31:0]; the result is bit 31 sign-extended to 64.
  - sra fills from op_a_i[31].
  - srl zero-fills from bit 31 down before sign extension.
  - Only add, sub, sll, srl, sra are legal as word ops; any other code sets illegal_o.
- Illegal op: still completes with latency 1, result_o=0, zero_o=1, illegal_o=1.
- zero_o and illegal_o are registered together with result_o.
- flush_i has priority over everything:
  - Next cycle: valid_o=0, state=IDLE, shift counter cleared.
  - An operation presented in the same cycle as flush_i is dropped.
  - result_o holds its last value.
- Reset values: valid_o=0, result_o=0, zero_o=0, illegal_o=0, state=IDLE, ready_o=1 in the first cycle after reset.
- Reset asserted mid-shift abandons the operation; no result is produced.

## Timing
- Non-shift ops, and all ops without ALU_SERIAL_SHIFT_EN:
  - Accepted at edge N; valid_o=1 with the result after edge N.
  - Throughput 1/cycle while ready_i=1.
- Serial shift, shift amount k>0:
  - Accepted at edge N; IDLE→SHIFT.
  - One bit shifted per edge; counter loads k and decrements.
  - At count 1: SHIFT→IDLE, valid_o=1 after edge N+k.
  - ready_o=0 throughout SHIFT.
- Serial shift, k=0: behaves as latency 1; the result is op_a_i (sign-extended for word ops).
- Back-pressure: while valid_o & ~ready_i, all outputs hold and ready_o=0.
- When valid_o & ready_i, a new op may be accepted in the same cycle; there is no bubble.

## Configuration
- ALU_SERIAL_SHIFT_EN defined:
  - sll/srl/sra run through the SHIFT state, one bit per cycle.
  - Latency is max(1, k) cycles.
- ALU_SERIAL_SHIFT_EN undefined:
  - Single-cycle barrel shifter; the SHIFT state and counter are absent.
  - Every op has latency 1.

## Test plan
- XLEN=64, op 1000, A=5, B=7, ready_i=1 → next cycle valid_o=1, result_o=0xFFFF_FFFF_FFFF_FFFE, zero_o=0.
- Op 1101, alu_op_32b_i=1, A=0x0000_0000_8000_0000, B=4 → result_o=0xFFFF_FFFF_F800_0000. With ALU_SERIAL_SHIFT_EN: valid_o after 4 edges and ready_o=0 for cycles 1-4.
- Op 0010, A=−1, B=1 → result_o=1. Op 0011 with the same operands → result_o=0, zero_o=1.
- Op 1111, and op 0100 with alu_op_32b_i=1 → illegal_o=1, result_o=0, latency 1.
- Hold ready_i=0 for 3 cycles after a result → result_o/valid_o stable and ready_o=0. Then ready_i=1 with valid_i=1 → new op accepted in that same cycle.
- Start sll with B=20 (serial build); assert flush_i on cycle 5 → valid_o never rises, ready_o=1 next cycle. Repeat the same sequence with rst_i instead of flush_i → identical behaviour.
